traffic_ctrl_xing: RTL

TRAFFIC_CTRL_XING -- requirements
Module: traffic_ctrl_xing

---
 rtl/traffic_ctrl_xing.sv | 117 +++++++++++
 1 files changed

// File: rtl/traffic_ctrl_xing.sv
// Two-way crossing controller: fixed-time NS/EW cycle with all-red clearance,
// pedestrian green shortening and a flashing-yellow night/fault mode.
module traffic_ctrl_xing #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_GREEN  = 60,
  parameter int unsigned T_YELLOW = 5,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_PED    = 10,
  parameter int unsigned T_FLASH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pass_request,
  input  logic             flash_en,
  output logic             ns_red,
  output logic             ns_yellow,
  output logic             ns_green,
  output logic             ew_red,
  output logic             ew_yellow,
  output logic             ew_green,
  output logic [CNT_W-1:0] clock,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_2  = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(T_PED - 1);
  localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(T_FLASH - 1);

  state_t           state, state_nx, succ;
  logic [CNT_W-1:0] cnt, cnt_nx, succ_ld;
  logic             flash, flash_nx;
  // Lamp order: ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green
  logic [5:0]       lamps, lamps_nx;

  always_comb begin
    succ    = NS_GREEN;
    succ_ld = LD_GREEN;
    case (state)
      NS_GREEN:  begin succ = NS_YELLOW; succ_ld = LD_YELLOW; end
      NS_YELLOW: begin succ = ALLRED_1;  succ_ld = LD_ALLRED; end
      ALLRED_1:  begin succ = EW_GREEN;  succ_ld = LD_GREEN;  end
      EW_GREEN:  begin succ = EW_YELLOW; succ_ld = LD_YELLOW; end
      EW_YELLOW: begin succ = ALLRED_2;  succ_ld = LD_ALLRED; end
      default:   begin succ = NS_GREEN;  succ_ld = LD_GREEN;  end
    endcase
  end

  // Priority: flash entry > flash handling > pedestrian shortening > countdown
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - CNT_W'(1);
    flash_nx = flash;
    if (state != FLASH && flash_en) begin
      state_nx = FLASH;
      cnt_nx   = LD_FLASH;
      flash_nx = 1'b1;
    end else if (state == FLASH) begin
      if (!flash_en) begin
        state_nx = ALLRED_2;
        cnt_nx   = LD_ALLRED;
        flash_nx = 1'b0;
      end else if (cnt == '0) begin
        cnt_nx   = LD_FLASH;
        flash_nx = ~flash;
      end
    end else if (pass_request && (state == NS_GREEN || state == EW_GREEN) && cnt > LD_PED) begin
      cnt_nx = LD_PED;
    end else if (cnt == '0) begin
      state_nx = succ;
      cnt_nx   = succ_ld;
    end
  end

  // Lamps are registered from the next state so they line up with phase
  always_comb begin
    lamps_nx = 6'b100100;
    case (state_nx)
      NS_GREEN:  lamps_nx = 6'b001100;
      NS_YELLOW: lamps_nx = 6'b010100;
      EW_GREEN:  lamps_nx = 6'b100001;
      EW_YELLOW: lamps_nx = 6'b100010;
      FLASH:     lamps_nx = {1'b0, flash_nx, 1'b0, 1'b0, flash_nx, 1'b0};
      default:   lamps_nx = 6'b100100;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ALLRED_2;
      cnt   <= LD_ALLRED;
      flash <= 1'b0;
      lamps <= 6'b100100;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      flash <= flash_nx;
      lamps <= lamps_nx;
    end
  end

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamps;
  assign clock = cnt;
  assign phase = state;

endmodule
